bus_master_if: RTL
==================

Name: bus_master_if

Overview:
- Parametrised CPU memory-stage bus interface and successor of the single-slave bus interface block.
- Decodes the slave index from the upper CPU address bits and routes the access in one of two ways:
  - a zero-wait combinational path to a configurable scratch-pad (SPM) slave;
  - a request/grant/ready master FSM on the system bus.
- Adds byte enables, flush abort during arbitration, a bus-timeout error response, and a hold buffer for read data and error status while the pipeline stalls.

Parameters:
- BUS_ADD_WIDTH, 30, word-address width.
- BUS_DAT_WIDTH, 32, data width; must be a multiple of 8.
- BUS_SLAV_WIDTH, 3, number of upper address bits forming the slave index.
- SPM_SLAVE_ID, 1, slave index that selects the SPM path.
- TIMEOUT_CYC, 255, maximum ACC cycles without bus_rdy_i; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- pip_stall_i  in  1  pipeline stall
- pip_flush_i  in  1  pipeline flush
- pip_busy_o  out  1  request that the pipeline stalls
- cpu_addr_i  in  BUS_ADD_WIDTH  access address
- cpu_acs_i  in  1  access strobe
- cpu_rw_i  in  1  1 = read, 0 = write
- cpu_be_i  in  BUS_DAT_WIDTH/8  byte enables
- cpu_wr_data_i  in  BUS_DAT_WIDTH  write data
- cpu_rd_data_o  out  BUS_DAT_WIDTH  read data
- cpu_err_o  out  1  access terminated by timeout
- spm_rd_data_i  in  BUS_DAT_WIDTH  SPM read data
- spm_addr_o  out  BUS_ADD_WIDTH  SPM address (pass-through)
- spm_as_o  out  1  SPM select
- spm_rw_o  out  1  SPM read/write (pass-through)
- spm_be_o  out  BUS_DAT_WIDTH/8  SPM byte enables (pass-through)
- spm_wr_data_o  out  BUS_DAT_WIDTH  SPM write data (pass-through)
- bus_rd_data_i  in  BUS_DAT_WIDTH  bus read data
- bus_rdy_i  in  1  bus slave ready
- bus_grnt_i  in  1  arbiter grant
- bus_req_o  out  1  bus request (registered)
- bus_addr_o  out  BUS_ADD_WIDTH  bus address (registered)
- bus_as_o  out  1  bus address strobe (registered)
- bus_rw_o  out  1  bus read/write (registered)
- bus_be_o  out  BUS_DAT_WIDTH/8  bus byte enables (registered)
- bus_wr_data_o  out  BUS_DAT_WIDTH  bus write data (registered)

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous, active-high.
- Reset values: state=IDLE; bus_req_o, bus_as_o, bus_addr_o, bus_be_o, bus_wr_data_o, rd_buf, err_buf, wait counter all 0; bus_rw_o=1. With state IDLE and cpu_acs_i=0, all combinational outputs are 0.
- Slave index: slv = cpu_addr_i[BUS_ADD_WIDTH-1 -: BUS_SLAV_WIDTH]. A valid access is cpu_acs_i & ~pip_flush_i.
- SPM pass-through: spm_addr_o, spm_rw_o, spm_be_o and spm_wr_data_o always follow the CPU inputs.
- IDLE state:
  - Valid access with slv==SPM_SLAVE_ID:
    - spm_as_o = ~pip_stall_i;
    - on a read, cpu_rd_data_o = spm_rd_data_i in the same cycle;
    - pip_busy_o=0.
  - Valid access with slv!=SPM_SLAVE_ID:
    - pip_busy_o=1 in the same cycle;
    - register addr, rw, be and wr_data onto the bus outputs;
    - bus_req_o<=1; go to REQ.
- REQ state:
  - pip_busy_o=1.
  - If pip_flush_i: bus_req_o<=0, restore the bus outputs to their reset values, go to IDLE. Flush has priority over grant.
  - Else if bus_grnt_i: bus_as_o<=1, wait counter<=0, go to ACC.
- ACC state:
  - bus_as_o stays 1; flush is ignored once the bus is granted.
  - Wait counter increments each cycle while bus_rdy_i=0.
  - Completion cycle (bus_rdy_i=1):
    - pip_busy_o=0;
    - on a read, cpu_rd_data_o = bus_rd_data_i in the same cycle;
    - rd_buf<=bus_rd_data_i (reads only), err_buf<=0;
    - bus_req_o, bus_as_o, bus_addr_o, bus_be_o, bus_wr_data_o <= 0; bus_rw_o<=1.
  - Timeout (TIMEOUT_CYC!=0, counter==TIMEOUT_CYC-1, bus_rdy_i=0):
    - treated as a completion with cpu_err_o=1 and cpu_rd_data_o=0;
    - rd_buf<=0, err_buf<=1.
  - bus_rdy_i wins over the timeout when both occur in the same cycle.
  - After a completion or timeout: go to HOLD if pip_stall_i, else IDLE.
  - Otherwise pip_busy_o=1.
- HOLD state:
  - cpu_rd_data_o = rd_buf (reads); cpu_err_o = err_buf.
  - pip_busy_o=0; no new access is started.
  - Go to IDLE on the first cycle with pip_stall_i=0. The outputs remain valid during that cycle.
- Mid-operation reset: rst_i in any state returns to IDLE next cycle with reset values, and bus_req_o and bus_as_o drop to 0 on that edge.
- Counter width: $clog2(TIMEOUT_CYC+1), minimum 1; the counter never wraps.

Test Plan:
- SPM read, addr=30'h0800_0010 (slv=1), spm_rd_data_i=32'hCAFE_F00D, no stall -> spm_as_o=1 and cpu_rd_data_o=CAFE_F00D in the same cycle; pip_busy_o=0; bus_req_o stays 0.
- Bus write, addr=30'h1000_0004 (slv=2), be=4'b0011, data=32'h1234_5678; grant after 2 cycles; rdy after 3 ACC cycles:
  - bus_req_o rises the cycle after the access;
  - bus_as_o rises the cycle after grant;
  - bus_be_o=0011 and bus_wr_data_o=12345678 are stable until rdy;
  - pip_busy_o is 1 through every cycle before rdy;
  - all bus outputs return to reset values the cycle after rdy.
- Bus read with pip_stall_i=1 at rdy, bus_rd_data_i=32'hA5A5_0001:
  - state goes to HOLD;
  - cpu_rd_data_o=A5A5_0001 for 4 stall cycles;
  - returns to IDLE when stall drops.
- Flush in REQ before grant -> bus_req_o=0 next cycle; IDLE; no bus_as_o pulse; a later grant is ignored.
- TIMEOUT_CYC=4, grant given, bus_rdy_i held 0 -> on the 4th ACC cycle cpu_err_o=1, cpu_rd_data_o=0, pip_busy_o=0, and bus_req_o/bus_as_o drop on the next edge. Repeat with rdy coincident on the 4th cycle -> cpu_err_o=0.
- rst_i asserted for 1 cycle during ACC -> next cycle state=IDLE, bus_req_o=0, bus_as_o=0, bus_rw_o=1; a following SPM access works normally.

Source files
------------

// File: rtl/bus_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_master_if
//  Description : CPU memory-stage bus interface. Decodes the slave index from
//                the upper address bits and either serves the access through
//                a zero-wait combinational scratch-pad (SPM) path or runs a
//                request/grant/ready master handshake on the system bus.
//                Supports byte enables, flush abort while arbitrating, a bus
//                timeout that completes the access with an error, and a hold
//                buffer that keeps read data / error visible while the
//                pipeline is stalled.
//  Ports       : clk_i, rst_i          - clock, synchronous active-high reset
//                pip_*                 - pipeline stall/flush in, busy out
//                cpu_*                 - CPU access request and response
//                spm_*                 - scratch-pad slave (combinational)
//                bus_*                 - system bus master (registered outputs)
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_master_if #(
    parameter int BUS_ADD_WIDTH  = 30,
    parameter int BUS_DAT_WIDTH  = 32,
    parameter int BUS_SLAV_WIDTH = 3,
    parameter int SPM_SLAVE_ID   = 1,
    parameter int TIMEOUT_CYC    = 255
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       pip_stall_i,
    input  logic                       pip_flush_i,
    output logic                       pip_busy_o,
    input  logic [BUS_ADD_WIDTH-1:0]   cpu_addr_i,
    input  logic                       cpu_acs_i,
    input  logic                       cpu_rw_i,
    input  logic [BUS_DAT_WIDTH/8-1:0] cpu_be_i,
    input  logic [BUS_DAT_WIDTH-1:0]   cpu_wr_data_i,
    output logic [BUS_DAT_WIDTH-1:0]   cpu_rd_data_o,
    output logic                       cpu_err_o,
    input  logic [BUS_DAT_WIDTH-1:0]   spm_rd_data_i,
    output logic [BUS_ADD_WIDTH-1:0]   spm_addr_o,
    output logic                       spm_as_o,
    output logic                       spm_rw_o,
    output logic [BUS_DAT_WIDTH/8-1:0] spm_be_o,
    output logic [BUS_DAT_WIDTH-1:0]   spm_wr_data_o,
    input  logic [BUS_DAT_WIDTH-1:0]   bus_rd_data_i,
    input  logic                       bus_rdy_i,
    input  logic                       bus_grnt_i,
    output logic                       bus_req_o,
    output logic [BUS_ADD_WIDTH-1:0]   bus_addr_o,
    output logic                       bus_as_o,
    output logic                       bus_rw_o,
    output logic [BUS_DAT_WIDTH/8-1:0] bus_be_o,
    output logic [BUS_DAT_WIDTH-1:0]   bus_wr_data_o
);

    localparam int BE_W    = BUS_DAT_WIDTH / 8;
    localparam int CNT_RAW = $clog2(TIMEOUT_CYC + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_acc  = 2'd2;
    localparam logic [1:0] c_st_hold = 2'd3;

    localparam logic [BUS_SLAV_WIDTH-1:0] c_spm_id  = BUS_SLAV_WIDTH'(SPM_SLAVE_ID);
    localparam logic [CNT_W-1:0]          c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0]          c_cnt_max = '1;
    localparam logic [CNT_W-1:0]          c_to_last =
        CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

    logic [1:0]               r_state_q,   w_state_d;
    logic                     r_bus_req_q, w_bus_req_d;
    logic                     r_bus_as_q,  w_bus_as_d;
    logic                     r_bus_rw_q,  w_bus_rw_d;
    logic [BUS_ADD_WIDTH-1:0] r_bus_addr_q, w_bus_addr_d;
    logic [BE_W-1:0]          r_bus_be_q,   w_bus_be_d;
    logic [BUS_DAT_WIDTH-1:0] r_bus_wdat_q, w_bus_wdat_d;
    logic [BUS_DAT_WIDTH-1:0] r_rd_buf_q,   w_rd_buf_d;
    logic                     r_err_buf_q,  w_err_buf_d;
    logic                     r_hold_rd_q,  w_hold_rd_d;   // held access was a read
    logic [CNT_W-1:0]         r_cnt_q,      w_cnt_d;

    logic [BUS_SLAV_WIDTH-1:0] w_slv;
    logic                      w_valid;
    logic                      w_timeout;

    assign w_slv   = cpu_addr_i[BUS_ADD_WIDTH-1 -: BUS_SLAV_WIDTH];
    assign w_valid = cpu_acs_i & ~pip_flush_i;

    // The scratch-pad sees the CPU request unchanged; only the select is gated.
    assign spm_addr_o    = cpu_addr_i;
    assign spm_rw_o      = cpu_rw_i;
    assign spm_be_o      = cpu_be_i;
    assign spm_wr_data_o = cpu_wr_data_i;

    generate
        if (TIMEOUT_CYC > 0) begin : g_timeout_en
            assign w_timeout = (r_cnt_q == c_to_last);
        end else begin : g_timeout_dis
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_comb begin
        w_state_d     = r_state_q;
        w_bus_req_d   = r_bus_req_q;
        w_bus_as_d    = r_bus_as_q;
        w_bus_rw_d    = r_bus_rw_q;
        w_bus_addr_d  = r_bus_addr_q;
        w_bus_be_d    = r_bus_be_q;
        w_bus_wdat_d  = r_bus_wdat_q;
        w_rd_buf_d    = r_rd_buf_q;
        w_err_buf_d   = r_err_buf_q;
        w_hold_rd_d   = r_hold_rd_q;
        w_cnt_d       = r_cnt_q;
        pip_busy_o    = 1'b0;
        cpu_rd_data_o = '0;
        cpu_err_o     = 1'b0;
        spm_as_o      = 1'b0;

        case (r_state_q)
            c_st_idle: begin
                if (w_valid) begin
                    if (w_slv == c_spm_id) begin
                        // A stalled pipeline must not let the SPM commit a write twice.
                        spm_as_o = ~pip_stall_i;
                        if (cpu_rw_i) begin
                            cpu_rd_data_o = spm_rd_data_i;
                        end
                    end else begin
                        pip_busy_o   = 1'b1;
                        w_bus_req_d  = 1'b1;
                        w_bus_addr_d = cpu_addr_i;
                        w_bus_rw_d   = cpu_rw_i;
                        w_bus_be_d   = cpu_be_i;
                        w_bus_wdat_d = cpu_wr_data_i;
                        w_state_d    = c_st_req;
                    end
                end
            end

            c_st_req: begin
                pip_busy_o = 1'b1;
                // Flush wins over a same-cycle grant: nothing has reached the bus yet.
                if (pip_flush_i) begin
                    w_bus_req_d  = 1'b0;
                    w_bus_as_d   = 1'b0;
                    w_bus_rw_d   = 1'b1;
                    w_bus_addr_d = '0;
                    w_bus_be_d   = '0;
                    w_bus_wdat_d = '0;
                    w_state_d    = c_st_idle;
                end else if (bus_grnt_i) begin
                    w_bus_as_d = 1'b1;
                    w_cnt_d    = '0;
                    w_state_d  = c_st_acc;
                end
            end

            c_st_acc: begin
                if (bus_rdy_i || w_timeout) begin
                    // Ready takes precedence over a timeout in the same cycle.
                    if (bus_rdy_i) begin
                        if (r_bus_rw_q) begin
                            cpu_rd_data_o = bus_rd_data_i;
                            w_rd_buf_d    = bus_rd_data_i;
                        end
                        w_err_buf_d = 1'b0;
                    end else begin
                        cpu_err_o   = 1'b1;
                        w_rd_buf_d  = '0;
                        w_err_buf_d = 1'b1;
                    end
                    w_hold_rd_d  = r_bus_rw_q;
                    w_bus_req_d  = 1'b0;
                    w_bus_as_d   = 1'b0;
                    w_bus_rw_d   = 1'b1;
                    w_bus_addr_d = '0;
                    w_bus_be_d   = '0;
                    w_bus_wdat_d = '0;
                    w_state_d    = pip_stall_i ? c_st_hold : c_st_idle;
                end else begin
                    pip_busy_o = 1'b1;
                    if (r_cnt_q != c_cnt_max) begin
                        w_cnt_d = r_cnt_q + c_cnt_one;
                    end
                end
            end

            c_st_hold: begin
                if (r_hold_rd_q) begin
                    cpu_rd_data_o = r_rd_buf_q;
                end
                cpu_err_o = r_err_buf_q;
                if (!pip_stall_i) begin
                    w_state_d = c_st_idle;
                end
            end

            default: begin
                w_state_d = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q    <= c_st_idle;
            r_bus_req_q  <= 1'b0;
            r_bus_as_q   <= 1'b0;
            r_bus_rw_q   <= 1'b1;
            r_bus_addr_q <= '0;
            r_bus_be_q   <= '0;
            r_bus_wdat_q <= '0;
            r_rd_buf_q   <= '0;
            r_err_buf_q  <= 1'b0;
            r_hold_rd_q  <= 1'b0;
            r_cnt_q      <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_bus_req_q  <= w_bus_req_d;
            r_bus_as_q   <= w_bus_as_d;
            r_bus_rw_q   <= w_bus_rw_d;
            r_bus_addr_q <= w_bus_addr_d;
            r_bus_be_q   <= w_bus_be_d;
            r_bus_wdat_q <= w_bus_wdat_d;
            r_rd_buf_q   <= w_rd_buf_d;
            r_err_buf_q  <= w_err_buf_d;
            r_hold_rd_q  <= w_hold_rd_d;
            r_cnt_q      <= w_cnt_d;
        end
    end

    assign bus_req_o     = r_bus_req_q;
    assign bus_as_o      = r_bus_as_q;
    assign bus_rw_o      = r_bus_rw_q;
    assign bus_addr_o    = r_bus_addr_q;
    assign bus_be_o      = r_bus_be_q;
    assign bus_wr_data_o = r_bus_wdat_q;

endmodule
`default_nettype wire
